// File: rtl/mmu_sched_pkg.sv
// Shared types and sizes for the 2x2 mmu scheduler.
package mmu_sched_pkg;

  localparam int N_REQ  = 2;
  localparam int ELEM_W = 8;
  localparam int MAT_W  = 4 * ELEM_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    RESP   = 2'd3
  } sched_state_e;

  // Selects requester idx's 32-bit matrix from a packed two-requester bus.
  function automatic logic [MAT_W-1:0] req_slice(input logic [N_REQ*MAT_W-1:0] bus,
                                                 input logic                   idx);
    logic [MAT_W-1:0] m;
    if (idx) begin
      m = bus[2*MAT_W-1:MAT_W];
    end else begin
      m = bus[MAT_W-1:0];
    end
    return m;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time is chosen.
module rr_arb2
  import mmu_sched_pkg::*;
(
  input  logic [N_REQ-1:0] valid,
  input  logic             last_grant,
  output logic             winner,
  output logic             any_valid
);

  // Winner is the sole valid requester, or the non-last one on a tie.
  always_comb begin
    any_valid = |valid;
    if (valid == 2'b11) begin
      winner = ~last_grant;
    end else begin
      winner = valid[1];
    end
  end

endmodule

// File: rtl/mmu_scheduler.sv
// Round-robin sequencer feeding one 2x2 mmu from two requesters, one job in flight.
// Optional abort-on-timeout path is enabled by defining MMU_SCHED_TIMEOUT_EN.
module mmu_scheduler
  import mmu_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*MAT_W-1:0] req_a,
  input  logic [N_REQ*MAT_W-1:0] req_b,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [MAT_W-1:0]       rsp_c,
  output logic                   rsp_err,
  output logic                   mmu_rst,
  output logic [MAT_W-1:0]       mmu_a,
  output logic [MAT_W-1:0]       mmu_b,
  input  logic [MAT_W-1:0]       mmu_c,
  input  logic                   mmu_done,
  output logic                   busy,
  output logic                   grant_id
);

  sched_state_e     state_q;
  logic             last_grant_q;
  logic             grant_q;
  logic             mmu_rst_q;
  logic [MAT_W-1:0] mmu_a_q;
  logic [MAT_W-1:0] mmu_b_q;
  logic [MAT_W-1:0] rsp_c_q;
  logic             winner_s;
  logic             any_valid_s;

`ifdef MMU_SCHED_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] run_cnt_q;
  logic             err_q;

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  rr_arb2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .winner     (winner_s),
    .any_valid  (any_valid_s)
  );

  assign mmu_rst  = mmu_rst_q;
  assign mmu_a    = mmu_a_q;
  assign mmu_b    = mmu_b_q;
  assign rsp_c    = rsp_c_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);

  // Ready only the arbitration winner, and only while idle.
  always_comb begin
    if ((state_q == IDLE) && any_valid_s) begin
      req_ready = winner_s ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
  end

  // Response is presented only to the owner of the finished job.
  always_comb begin
    if (state_q == RESP) begin
      rsp_valid = grant_q ? 2'b10 : 2'b01;
    end else begin
      rsp_valid = 2'b00;
    end
  end

  // Job sequencing FSM; mmu_rst_q tracks the state so the mmu only runs in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      mmu_rst_q    <= 1'b1;
      mmu_a_q      <= '0;
      mmu_b_q      <= '0;
      rsp_c_q      <= '0;
`ifdef MMU_SCHED_TIMEOUT_EN
      run_cnt_q    <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          mmu_rst_q <= 1'b1;
          if (any_valid_s) begin
            mmu_a_q <= req_slice(req_a, winner_s);
            mmu_b_q <= req_slice(req_b, winner_s);
            grant_q <= winner_s;
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
`ifdef MMU_SCHED_TIMEOUT_EN
          run_cnt_q <= '0;
`endif
          mmu_rst_q <= 1'b0;
          state_q   <= RUN;
        end
        RUN: begin
          if (mmu_done) begin
            rsp_c_q   <= mmu_c;
`ifdef MMU_SCHED_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            mmu_rst_q <= 1'b1;
            state_q   <= RESP;
          end
`ifdef MMU_SCHED_TIMEOUT_EN
          else if (run_cnt_q == CNT_LAST) begin
            rsp_c_q   <= '0;
            err_q     <= 1'b1;
            mmu_rst_q <= 1'b1;
            state_q   <= RESP;
          end else begin
            run_cnt_q <= run_cnt_q + 1'b1;
          end
`endif
        end
        RESP: begin
          mmu_rst_q <= 1'b1;
          if (rsp_ready[grant_q]) begin
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end
        end
        default: begin
          mmu_rst_q <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mmu_scheduler.md
# mmu_scheduler

Sequencer and arbiter for the single 2x2 matrix-multiply unit (mmu). It accepts multiply jobs from two requesters over valid/ready handshakes and grants the unit round-robin. For each granted job it drives the operands and the mmu's active-high clear/hold input, waits for the unit's done flag, and returns the 2x2 result to the granting requester. It sits between the host-facing load/readout logic and the mmu, so the mmu does not need a dedicated loader per requester.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: maximum number of RUN cycles before a job is aborted. Used only with MMU_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  2  bit r: requester r offers a job
- req_ready  out  2  bit r: job from requester r accepted this cycle
- req_a  in  64  A operands; requester r occupies [32r+31:32r]; element i (i = row*2+col) occupies [8i+7:8i]
- req_b  in  64  B operands; packing identical to req_a
- rsp_valid  out  2  bit r: result for requester r is available
- rsp_ready  in  2  bit r: requester r takes the result
- rsp_c  out  32  result matrix, packed as for A
- rsp_err  out  1  job was aborted by timeout; 0 when the macro is undefined
- mmu_rst  out  1  registered; 1 holds the mmu cleared, 0 lets it run
- mmu_a, mmu_b  out  32  operand registers driven to the mmu
- mmu_c  in  32  mmu result
- mmu_done  in  1  mmu completion flag
- busy  out  1  state != IDLE
- grant_id  out  1  requester that owns the current job

## Operation
States:
- **IDLE**: mmu_rst=1.
  - If any req_valid bit is set, the block picks a winner: the requester whose valid bit is set; if both are set, the requester != last_grant.
  - req_ready = winner bit only, combinational, and only in IDLE.
  - On valid&ready: latch operands into mmu_a/mmu_b, set grant_id=winner, go to LAUNCH.
- **LAUNCH**: exactly 1 cycle. mmu_rst stays 1 and operands are stable. Clear the run counter. Go to RUN.
- **RUN**: mmu_rst=0.
  - When mmu_done=1: capture mmu_c into the result register, set err=0, go to RESP.
  - With the macro defined: when the counter reaches TIMEOUT_CYCLES-1 without mmu_done, set result=0, err=1, go to RESP.
  - mmu_done and timeout in the same cycle: mmu_done wins.
- **RESP**: mmu_rst=1.
  - rsp_valid[grant_id]=1, the other rsp_valid bit is 0; rsp_c and rsp_err are held stable.
  - On rsp_ready[grant_id]: set last_grant=grant_id, go to IDLE.
  - rsp_ready of the non-owner is ignored.

Rules:
- mmu_done is ignored outside RUN.
- Only one job is in flight at a time; requests arriving during busy wait with valid held.
- A requester must hold req_valid and its operands until it sees ready.

## Timing
Reset values:
- state=IDLE, last_grant=1 (requester 0 wins the first tie), grant_id=0.
- mmu_rst=1, mmu_a=mmu_b=0, rsp_valid=0, rsp_c=0, rsp_err=0, busy=0.

Latency:
- Handshake at cycle T, LAUNCH at T+1, mmu_rst=0 from T+2.
- mmu_done sampled at cycle D gives rsp_valid=1 at D+1 and mmu_rst=1 at D+1.
- Response handshake at cycle R: IDLE at R+1, where the next job can be accepted in the same cycle R+1.
- Throughput: one job per (mmu latency + 4) cycles, minimum.

Reset mid-operation: the block returns to the reset state on the next edge. The in-flight job is dropped and no response is issued.

Timeout: counts RUN cycles only; exactly TIMEOUT_CYCLES RUN cycles elapse before RESP.

## Configuration
MMU_SCHED_TIMEOUT_EN:
- Defined: run counter (width $clog2(TIMEOUT_CYCLES)) and abort path present; rsp_err reports aborts.
- Undefined: no counter; RUN waits indefinitely for mmu_done; rsp_err is tied to 0.

## Structure
Package mmu_sched_pkg holds:
- N_REQ=2, ELEM_W=8, MAT_W=32.
- State enum {IDLE, LAUNCH, RUN, RESP}.

Sub-module rr_arb2: combinational 2-way round-robin picker. Inputs are valid[1:0] and last_grant; outputs are winner and any_valid.

## Test plan
- A=0x04030201 and B=0x08070605 on requester 0, mmu model done 5 cycles after mmu_rst falls -> rsp_valid[0] one cycle after done, rsp_c=0x322B1613 (19,22,43,50), rsp_err=0.
- Both requesters valid from the first cycle after reset -> requester 0 is served first, then requester 1; with both still valid afterwards, grants alternate 0,1,0,1.
- rsp_ready[0] held low for 10 cycles, with requester 1 valid -> rsp_c stable, req_ready[1] stays 0, requester 1 is accepted the cycle after the rsp_ready[0] handshake.
- With the macro defined and TIMEOUT_CYCLES=8, mmu_done never asserts -> RESP after 8 RUN cycles, rsp_c=0, rsp_err=1, mmu_rst=1.
- rst asserted during RUN -> next cycle IDLE, mmu_rst=1, no rsp_valid; a new job completes normally afterwards.
- mmu_done pulsed during IDLE and LAUNCH -> ignored; the job completes only on a done pulse seen in RUN.
